xor_share_arb: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one external 32-bit XOR unit between two requesters (e.g. the ALU issue path and the checksum engine). It grants one requester at a time, steers the winner's operands to the XOR unit, and captures the result in a one-entry output register. The result is returned only to the granted requester over a valid/ready response channel. The block sits between the requesters and a single `xor_32` instance, which it drives through the `xor_a`/`xor_b`/`xor_s` ports.

---
 rtl/xor_share_arb.sv | 120 ++++++++++++
 tb/tb_xor_share_arb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/xor_share_arb.sv
// xor_share_arb: round-robin arbiter sharing one external XOR unit between
// two requesters. The winner's operands go to the XOR unit, and its result is
// captured in a one-entry register. The result is returned to the owning
// requester over a valid/ready channel. A drain and a new accept may happen
// in the same cycle, so the block sustains one operation per cycle.
module xor_share_arb #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rvalid,
    output logic [WIDTH-1:0] r0_rdata,
    input  logic             r0_rready,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rvalid,
    output logic [WIDTH-1:0] r1_rdata,
    input  logic             r1_rready,

    output logic [WIDTH-1:0] xor_a,
    output logic [WIDTH-1:0] xor_b,
    input  logic [WIDTH-1:0] xor_s,

    output logic [CNT_W-1:0] op_count
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic             state;
    logic             owner;
    logic             last;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] count;

    logic drain;
    logic space;
    logic gnt_valid;
    logic gnt_id;
    logic accept;

    // The result register frees up this cycle if it is empty or its owner is draining it.
    always_comb begin
        drain = (state == ST_FULL) && (owner ? r1_rready : r0_rready);
        space = (state == ST_EMPTY) || drain;
    end

    // Round-robin pick: a lone requester wins, and a tie goes to whoever was not served last.
    always_comb begin
        gnt_valid = r0_valid || r1_valid;
        gnt_id    = 1'b0;
        if (r0_valid && r1_valid) begin
            gnt_id = ~last;
        end else if (r1_valid) begin
            gnt_id = 1'b1;
        end
    end

    // Readiness is held low while in reset so nothing looks accepted during reset.
    always_comb begin
        accept   = space && gnt_valid && rst_n;
        r0_ready = accept && !gnt_id;
        r1_ready = accept && gnt_id;
    end

    // Steer the granted requester's operands to the shared XOR unit, or zero when idle.
    always_comb begin
        xor_a = '0;
        xor_b = '0;
        if (gnt_valid) begin
            xor_a = gnt_id ? r1_a : r0_a;
            xor_b = gnt_id ? r1_b : r0_b;
        end
    end

    // Return the held result only to its owner; rvalid comes purely from registers.
    always_comb begin
        r0_rvalid = (state == ST_FULL) && !owner;
        r1_rvalid = (state == ST_FULL) && owner;
        r0_rdata  = !owner ? res : '0;
        r1_rdata  = owner  ? res : '0;
        op_count  = count;
    end

    // Result register state: capture on accept, and go empty on a drain with no new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            owner <= 1'b0;
            last  <= 1'b1;
            res   <= '0;
        end else if (accept) begin
            state <= ST_FULL;
            owner <= gnt_id;
            last  <= gnt_id;
            res   <= xor_s;
        end else if (drain) begin
            state <= ST_EMPTY;
        end
    end

    // Count drained operations, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (drain) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_xor_share_arb.sv
// Directed testbench for xor_share_arb; the shared XOR unit is modelled inline.
module tb_xor_share_arb;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r0_ready, r0_rvalid, r0_rready;
    logic [31:0] r0_a, r0_b, r0_rdata;
    logic        r1_valid, r1_ready, r1_rvalid, r1_rready;
    logic [31:0] r1_a, r1_b, r1_rdata;
    logic [31:0] xor_a, xor_b, xor_s;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;

    xor_share_arb #(.WIDTH(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r0_rready (r0_rready),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .r1_rready (r1_rready),
        .xor_a     (xor_a),
        .xor_b     (xor_b),
        .xor_s     (xor_s),
        .op_count  (op_count)
    );

    // Stand-in for the external xor_32 unit.
    assign xor_s = xor_a ^ xor_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic rr0,
                                 input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic rr1);
        r0_valid  = v0;
        r0_a      = a0;
        r0_b      = b0;
        r0_rready = rr0;
        r1_valid  = v1;
        r1_a      = a1;
        r1_b      = b1;
        r1_rready = rr1;
        #1;
    endtask

    initial begin
        logic win;

        // Reset with arbitrary inputs driven
        rst_n = 1'b0;
        applyStimulus(1'b1, $urandom, $urandom, 1'b1, 1'b1, $urandom, $urandom, 1'b0);
        tick();
        tick();
        checkOutput("rst_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
        checkOutput("rst_r1_rvalid", {31'b0, r1_rvalid}, 32'd0);
        checkOutput("rst_r0_rdata", r0_rdata, 32'd0);
        checkOutput("rst_r1_rdata", r1_rdata, 32'd0);
        checkOutput("rst_op_count", {16'b0, op_count}, 32'd0);
        checkOutput("rst_r0_ready", {31'b0, r0_ready}, 32'd0);
        checkOutput("rst_r1_ready", {31'b0, r1_ready}, 32'd0);

        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_xor_a", xor_a, 32'd0);
        checkOutput("idle_xor_b", xor_b, 32'd0);

        // Single op from requester 0
        applyStimulus(1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput("single_r0_ready", {31'b0, r0_ready}, 32'd1);
        checkOutput("single_xor_a", xor_a, 32'hFFFF0000);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput("single_r0_rvalid", {31'b0, r0_rvalid}, 32'd1);
        checkOutput("single_r0_rdata", r0_rdata, 32'hF0F00F0F);
        checkOutput("single_r1_rvalid", {31'b0, r1_rvalid}, 32'd0);
        tick();
        checkOutput("single_op_count", {16'b0, op_count}, 32'd1);
        checkOutput("single_drained", {31'b0, r0_rvalid}, 32'd0);

        // Backpressure on requester 1 while requester 0 waits
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1, 32'h3, 1'b0);
        checkOutput("bp_r1_ready", {31'b0, r1_ready}, 32'd1);
        tick();
        applyStimulus(1'b1, 32'h10, 32'h01, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_hold_rvalid_%0d", i), {31'b0, r1_rvalid}, 32'd1);
            checkOutput($sformatf("bp_hold_rdata_%0d", i), r1_rdata, 32'h2);
            checkOutput($sformatf("bp_hold_r0_ready_%0d", i), {31'b0, r0_ready}, 32'd0);
            tick();
        end
        applyStimulus(1'b1, 32'h10, 32'h01, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("bp_release_r0_ready", {31'b0, r0_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput("bp_r0_rvalid", {31'b0, r0_rvalid}, 32'd1);
        checkOutput("bp_r0_rdata", r0_rdata, 32'h11);
        checkOutput("bp_r1_rvalid", {31'b0, r1_rvalid}, 32'd0);
        checkOutput("bp_op_count", {16'b0, op_count}, 32'd2);
        tick();
        checkOutput("bp_still_held", {31'b0, r0_rvalid}, 32'd1);

        // Reset while a result is held
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
        checkOutput("midrst_op_count", {16'b0, op_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
        checkOutput("post_rst_r1_rvalid", {31'b0, r1_rvalid}, 32'd0);

        // Tie round-robin at full throughput: grants must go 0,1,0,1
        applyStimulus(1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, 32'h12345678, 32'h12345678, 1'b1);
        for (int i = 0; i < 4; i++) begin
            win = logic'(i % 2);
            checkOutput($sformatf("tie_r0_ready_%0d", i), {31'b0, r0_ready}, {31'b0, ~win});
            checkOutput($sformatf("tie_r1_ready_%0d", i), {31'b0, r1_ready}, {31'b0, win});
            tick();
            if (win) begin
                checkOutput($sformatf("tie_r1_rvalid_%0d", i), {31'b0, r1_rvalid}, 32'd1);
                checkOutput($sformatf("tie_r1_rdata_%0d", i), r1_rdata, 32'h00000000);
            end else begin
                checkOutput($sformatf("tie_r0_rvalid_%0d", i), {31'b0, r0_rvalid}, 32'd1);
                checkOutput($sformatf("tie_r0_rdata_%0d", i), r0_rdata, 32'hFFFFFFFF);
            end
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        tick();
        checkOutput("tie_op_count", {16'b0, op_count}, 32'd4);

        // Counter wrap: fresh reset, then 65536 back-to-back drains
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h5, 32'h6, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 65536; i++) begin
            tick();
        end
        checkOutput("wrap_ffff", {16'b0, op_count}, 32'h0000FFFF);
        checkOutput("wrap_rdata", r0_rdata, 32'h3);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        checkOutput("wrap_zero", {16'b0, op_count}, 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
